// File: rtl/pc_pkg.sv
// Shared types and constants for the program counter datapath.
package pc_pkg;

    localparam int PC_WIDTH = 16;

    typedef logic [PC_WIDTH-1:0] pc_addr_t;

    localparam pc_addr_t RESET_ADDR = '0;

endpackage : pc_pkg

// File: rtl/pc_incrementer.sv
// Combinational add-one for the program counter; wraps modulo 2^WIDTH.
// There is no carry out.
module pc_incrementer #(
    parameter int WIDTH = pc_pkg::PC_WIDTH
) (
    input  logic [WIDTH-1:0] value_i,
    output logic [WIDTH-1:0] value_inc_o
);

    // The top bit carry is dropped, so all-ones + 1 becomes all-zeros.
    assign value_inc_o = value_i + WIDTH'(1);

endmodule : pc_incrementer

// File: rtl/program_counter.sv
// Program counter: registered instruction address, +1 each clock, load replaces it with data.
// Clears asynchronously to RESET_ADDR while the active-low reset is low.
module program_counter #(
    parameter int               WIDTH      = pc_pkg::PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_ADDR = WIDTH'(pc_pkg::RESET_ADDR)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    input  logic             load,
    output logic [WIDTH-1:0] out
);

    logic [WIDTH-1:0] pc_q;
    logic [WIDTH-1:0] pc_d;
    logic [WIDTH-1:0] pc_inc;

    pc_incrementer #(
        .WIDTH (WIDTH)
    ) u_inc (
        .value_i     (pc_q),
        .value_inc_o (pc_inc)
    );

    // A load replaces the value outright; it is never followed by an increment.
    always_comb begin
        pc_d = pc_inc;
        if (load) begin
            pc_d = data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_ADDR;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign out = pc_q;

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Self-checking bench for program_counter: expected addresses are queued as each
// edge is driven and popped when the registered output is sampled.
module tb_program_counter;

    logic        clk;
    logic        reset;
    logic [15:0] data;
    logic        load;
    logic [15:0] out;

    logic [15:0] exp_q[$];
    int          vectors;
    int          miscompares;
    logic [15:0] want;
    logic [15:0] model;

    program_counter dut (
        .clk   (clk),
        .reset (reset),
        .data  (data),
        .load  (load),
        .out   (out)
    );

    // Drive inputs with clk low, push the expected result, raise clk, and return
    // 1 time unit after the rising edge so out can be sampled off the edge.
    task automatic drive_edge(input logic ld, input logic [15:0] d, input logic [15:0] exp);
        clk  = 1'b0;
        load = ld;
        data = d;
        exp_q.push_back(exp);
        #5;
        clk = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        clk   = 1'b0;
        reset = 1'b1;
        load  = 1'b0;
        data  = 16'h0000;
        #1;
        reset = 1'b0;
        #2;
        exp_q.push_back(16'h0000);
        want = exp_q.pop_front();
        vectors++;
        if (out !== want) begin
            $display("FAIL reset_async: out=%h expected=%h", out, want);
            miscompares++;
        end
        for (int i = 0; i < 3; i++) begin
            drive_edge(1'b1, 16'hBEEF, 16'h0000);
            want = exp_q.pop_front();
            vectors++;
            if (out !== want) begin
                $display("FAIL reset_hold[%0d]: out=%h expected=%h", i, out, want);
                miscompares++;
            end
        end
        clk = 1'b0;
        #2;
    endtask

    task automatic test_count();
        reset = 1'b1;
        model = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            model = model + 16'h0001;
            drive_edge(1'b0, 16'hDEAD, model);
            want = exp_q.pop_front();
            vectors++;
            if (out !== want) begin
                $display("FAIL count[%0d]: out=%h expected=%h", i, out, want);
                miscompares++;
            end
        end
    endtask

    task automatic test_load();
        logic        ld_v[3]  = '{1'b1, 1'b0, 1'b0};
        logic [15:0] d_v[3]   = '{16'h002D, 16'h0000, 16'hFFFF};
        logic [15:0] e_v[3]   = '{16'h002D, 16'h002E, 16'h002F};
        for (int i = 0; i < 3; i++) begin
            drive_edge(ld_v[i], d_v[i], e_v[i]);
            want = exp_q.pop_front();
            vectors++;
            if (out !== want) begin
                $display("FAIL load[%0d]: out=%h expected=%h", i, out, want);
                miscompares++;
            end
        end
    endtask

    task automatic test_wrap();
        logic        ld_v[3]  = '{1'b1, 1'b0, 1'b0};
        logic [15:0] e_v[3]   = '{16'hFFFF, 16'h0000, 16'h0001};
        for (int i = 0; i < 3; i++) begin
            drive_edge(ld_v[i], 16'hFFFF, e_v[i]);
            want = exp_q.pop_front();
            vectors++;
            if (out !== want) begin
                $display("FAIL wrap[%0d]: out=%h expected=%h", i, out, want);
                miscompares++;
            end
        end
    endtask

    task automatic test_held_load();
        logic        ld_v[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        logic [15:0] d_v[5]   = '{16'h1234, 16'h1234, 16'h1234, 16'h0100, 16'h0100};
        logic [15:0] e_v[5]   = '{16'h1234, 16'h1234, 16'h1234, 16'h0100, 16'h0101};
        for (int i = 0; i < 5; i++) begin
            drive_edge(ld_v[i], d_v[i], e_v[i]);
            want = exp_q.pop_front();
            vectors++;
            if (out !== want) begin
                $display("FAIL held_load[%0d]: out=%h expected=%h", i, out, want);
                miscompares++;
            end
        end
    endtask

    task automatic test_reset_priority();
        clk  = 1'b0;
        load = 1'b1;
        data = 16'h00AA;
        #4;
        reset = 1'b0;
        #1;
        exp_q.push_back(16'h0000);
        want = exp_q.pop_front();
        vectors++;
        if (out !== want) begin
            $display("FAIL rst_prio_before_edge: out=%h expected=%h", out, want);
            miscompares++;
        end
        clk = 1'b1;
        #1;
        exp_q.push_back(16'h0000);
        want = exp_q.pop_front();
        vectors++;
        if (out !== want) begin
            $display("FAIL rst_prio_at_edge: out=%h expected=%h", out, want);
            miscompares++;
        end
        #4;
        clk = 1'b0;
        #2;
        reset = 1'b1;
        #2;
        drive_edge(1'b1, 16'h00AA, 16'h00AA);
        want = exp_q.pop_front();
        vectors++;
        if (out !== want) begin
            $display("FAIL rst_prio_release_load: out=%h expected=%h", out, want);
            miscompares++;
        end
        drive_edge(1'b0, 16'h0000, 16'h00AB);
        want = exp_q.pop_front();
        vectors++;
        if (out !== want) begin
            $display("FAIL rst_prio_release_inc: out=%h expected=%h", out, want);
            miscompares++;
        end
    endtask

    // Random mix of loads and increments against a running reference address.
    task automatic test_back_to_back();
        logic        ld;
        logic [15:0] d;
        model = 16'h00AB;
        for (int i = 0; i < 40; i++) begin
            ld = ($urandom_range(0, 2) == 0);
            d  = 16'($urandom);
            if (i % 10 == 9) d = 16'hFFFE;
            model = ld ? d : model + 16'h0001;
            drive_edge(ld, d, model);
            want = exp_q.pop_front();
            vectors++;
            if (out !== want) begin
                $display("FAIL back_to_back[%0d]: out=%h expected=%h ld=%0b d=%h", i, out, want, ld, d);
                miscompares++;
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        test_reset();
        test_count();
        test_load();
        test_wrap();
        test_held_load();
        test_reset_priority();
        test_back_to_back();
        if (exp_q.size() != 0) begin
            $display("FAIL scoreboard_drain: left=%0d expected=0", exp_q.size());
            miscompares++;
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_program_counter

// File: doc/program_counter.md
Name: program_counter

Overview:
- 16-bit program counter for the 16-bit computer datapath; supplies the instruction-memory address every cycle.
- Advances by one each clock. A load strobe replaces the count with a jump target from `data`.
- Clears asynchronously to address 0.

Parameters:
- WIDTH, 16, bit width of `data` and `out`; the counter wraps modulo 2^WIDTH.
- RESET_ADDR, 0, value forced onto `out` while reset is asserted.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset. 0 forces `out` to RESET_ADDR immediately; 1 means normal operation.
- data  input  WIDTH  jump/branch target, sampled on the rising clk edge when `load`=1.
- load  input  1  synchronous load strobe, active-high.
- out  output  WIDTH  current program counter value, registered.
- Positional order is fixed: clk, reset, data, load, out.

Behaviour:
- Single register `out`, updated only on posedge clk or on negedge reset.
- Reset:
  - reset=0 clears `out` to RESET_ADDR (0x0000) asynchronously, with no clock required.
  - `out` holds RESET_ADDR for as long as reset=0; clk, load and data are ignored.
- Reset release:
  - The first rising clk edge after reset returns to 1 performs a normal update (increment or load).
  - From reset, the first increment gives 0x0001.
- Priority per rising edge, when reset=1:
  - load=1: out <= data. Zero-latency load, so `data` is visible on `out` right after that edge.
  - load=0: out <= out + 1, truncated to WIDTH bits.
- Wrap-around:
  - 0xFFFF + 1 = 0x0000, with no flag or carry out.
  - A wrap after a load of 0xFFFF behaves identically.
- Simultaneous events:
  - Reset asserted in the same instant as a clk edge with load=1: reset wins, out = RESET_ADDR.
  - Load and increment never combine. A load replaces the value; it is not followed by an increment in the same cycle.
- Load duration:
  - load held high for N edges loads `data` on every one of those edges, so `out` tracks `data` and holds if `data` is constant.
  - Incrementing resumes on the first edge with load=0.
- Reset mid-operation: `out` clears immediately, regardless of a pending load.
- `data` and `load` are don't-care between clock edges. No combinational path from inputs to `out` except the asynchronous reset.
- No X-propagation tolerance is required on `data` when load=0.

Decomposition:
- Shared package `pc_pkg`:
  - localparam PC_WIDTH = 16
  - typedef `pc_addr_t` (logic [PC_WIDTH-1:0])
  - RESET_ADDR constant
- Sub-module `pc_incrementer`:
  - purely combinational, WIDTH-bit add-one, wrap-around, no carry out
  - instantiated once
- Top `program_counter` holds the next-value mux (load ? data : inc) and the async-reset register.

Test Plan:
- Reset: drive reset=0 for 2 ns with clk idle → out=0x0000 before any clk edge. Hold reset=0 across 3 edges → out stays 0x0000.
- Count: release reset, load=0, 5 rising edges → out steps 0x0001, 0x0002, 0x0003, 0x0004, 0x0005.
- Load:
  - From count 5, set data=45 (0x002D) and load=1 for one edge → out=0x002D.
  - load=0 for two edges → 0x002E, then 0x002F.
- Wrap: load data=0xFFFF, then load=0 for two edges → 0xFFFF, 0x0000, 0x0001.
- Held load: load=1 for 3 edges with data=0x1234 → out=0x1234 on all three. Change data to 0x0100 on edge 4 with load still 1 → 0x0100. Drop load → 0x0101.
- Reset priority: load=1, data=0x00AA, assert reset=0 just before a clk edge → out=0x0000 at the edge and after. On release, next edge with load=1 → 0x00AA.
